// File: rtl/divisor_sequencial_if.sv
// ---------------------------------------------------------------------------
// divisor_sequencial_if
//   Start/Done handshake and operand/result bundle of the sequential
//   restoring divider used by DIVU in the execute stage.
//
//   Signals
//     Start      master -> slave  request, sampled only while Busy=0
//     Dividendo  master -> slave  dividend, captured with an accepted Start
//     Divisor    master -> slave  divisor, captured with an accepted Start
//     Quociente  slave -> master  registered quotient, held until next result
//     Resto      slave -> master  registered remainder, held until next result
//     Busy       slave -> master  high while iterating
//     Done       slave -> master  one-cycle pulse when Quociente/Resto update
//     DivZero    slave -> master  result came from a zero divisor
//
//   Modports
//     master : requester side (execute stage / testbench)
//     slave  : divider side
// ---------------------------------------------------------------------------
interface divisor_sequencial_if #(
  parameter int WIDTH = 16
);

  logic             Start;
  logic [WIDTH-1:0] Dividendo;
  logic [WIDTH-1:0] Divisor;
  logic [WIDTH-1:0] Quociente;
  logic [WIDTH-1:0] Resto;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start,
    output Dividendo,
    output Divisor,
    input  Quociente,
    input  Resto,
    input  Busy,
    input  Done,
    input  DivZero
  );

  modport slave (
    input  Start,
    input  Dividendo,
    input  Divisor,
    output Quociente,
    output Resto,
    output Busy,
    output Done,
    output DivZero
  );

endinterface

// File: rtl/divisor_sequencial.sv
// ---------------------------------------------------------------------------
// divisor_sequencial
//   Unsigned sequential restoring divider producing one quotient bit per
//   clock. It mirrors the shift-add multiplier: the same (WIDTH+1)-bit
//   add/subtract width is used, with the extra bit acting as the borrow.
//
//   Parameters
//     WIDTH  operand, quotient and remainder width
//     CNT_W  iteration counter width, 2**CNT_W must exceed WIDTH
//
//   Ports
//     Clk    in   rising-edge clock
//     Reset  in   asynchronous active-high reset, discards any operation
//     bus    slave side of divisor_sequencial_if (Start, Dividendo, Divisor,
//            Quociente, Resto, Busy, Done, DivZero)
//
//   Timing
//     Start accepted at edge k with Divisor != 0 -> Done pulses after
//     edge k+WIDTH. With Divisor == 0 -> Done pulses after edge k with
//     Quociente = all ones, Resto = Dividendo, DivZero = 1.
// ---------------------------------------------------------------------------
module divisor_sequencial #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                   Clk,
  input  logic                   Reset,
  divisor_sequencial_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  // FSM
  state_t           state_r;
  state_t           stateNext_s;
  logic             loadOp_s;      // accepted Start with a non-zero divisor
  logic             loadZero_s;    // accepted Start with a zero divisor
  logic             finish_s;      // last iteration completes on this edge
  logic             lastIter_s;

  // Iteration datapath
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH:0]   remShift_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] remNext_s;
  logic [WIDTH-1:0] quoNext_s;

  // Registered results / status
  logic [WIDTH-1:0] quociente_r;
  logic [WIDTH-1:0] resto_r;
  logic             busy_r;
  logic             done_r;
  logic             divZero_r;

  assign lastIter_s = (cnt_r == CNT_W'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor at WIDTH+1 bits and keep the difference only when no borrow.
  // The partial remainder is always below the divisor, so it fits in WIDTH
  // bits; whenever the shifted value has its top bit set it is larger than
  // any divisor, the subtraction succeeds and no set bit is ever dropped.
  always_comb begin
    remShift_s = {rem_r, quo_r[WIDTH-1]};
    trial_s    = remShift_s - {1'b0, divisor_r};
    quoNext_s  = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};
    if (trial_s[WIDTH] == 1'b0) begin
      remNext_s = trial_s[WIDTH-1:0];
    end else begin
      remNext_s = remShift_s[WIDTH-1:0];
    end
  end

  // Next-state and control decode.
  // A divide-by-zero request that arrives while Done is still high is held
  // off for one edge so Done can never be high on two consecutive cycles;
  // Start is a level request, so a held Start is taken on the next edge.
  always_comb begin
    stateNext_s = state_r;
    loadOp_s    = 1'b0;
    loadZero_s  = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE, FIM: begin
        if (bus.Start) begin
          if (bus.Divisor != {WIDTH{1'b0}}) begin
            loadOp_s    = 1'b1;
            stateNext_s = CALC;
          end else if (!done_r) begin
            loadZero_s  = 1'b1;
            stateNext_s = FIM;
          end else begin
            stateNext_s = state_r;
          end
        end else begin
          stateNext_s = state_r;
        end
      end
      CALC: begin
        if (lastIter_s) begin
          finish_s    = 1'b1;
          stateNext_s = FIM;
        end else begin
          stateNext_s = CALC;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Operand latch and iteration registers; inputs are only read on load.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      divisor_r <= {WIDTH{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (loadOp_s) begin
      divisor_r <= bus.Divisor;
      quo_r     <= bus.Dividendo;
      rem_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (state_r == CALC) begin
      quo_r     <= quoNext_s;
      rem_r     <= remNext_s;
      cnt_r     <= cnt_r + CNT_W'(1);
    end else begin
      divisor_r <= divisor_r;
      quo_r     <= quo_r;
      rem_r     <= rem_r;
      cnt_r     <= cnt_r;
    end
  end

  // Result registers and status flags presented on the interface.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      quociente_r <= {WIDTH{1'b0}};
      resto_r     <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      divZero_r   <= 1'b0;
    end else begin
      busy_r <= (stateNext_s == CALC);
      done_r <= finish_s | loadZero_s;
      if (finish_s) begin
        quociente_r <= quoNext_s;
        resto_r     <= remNext_s;
      end else if (loadZero_s) begin
        quociente_r <= {WIDTH{1'b1}};
        resto_r     <= bus.Dividendo;
      end else begin
        quociente_r <= quociente_r;
        resto_r     <= resto_r;
      end
      if (loadZero_s) begin
        divZero_r <= 1'b1;
      end else if (loadOp_s) begin
        divZero_r <= 1'b0;
      end else begin
        divZero_r <= divZero_r;
      end
    end
  end

  assign bus.Quociente = quociente_r;
  assign bus.Resto     = resto_r;
  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.DivZero   = divZero_r;

endmodule

// File: tb/tb_divisor_sequencial.sv
// ---------------------------------------------------------------------------
// tb_divisor_sequencial
//   Directed and random checks of divisor_sequencial. Expected results are
//   computed with the simulator's own / and % operators, pushed to a
//   scoreboard queue when a request is driven and popped when Done pulses.
// ---------------------------------------------------------------------------
module tb_divisor_sequencial;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             z;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;

  exp_t sb[$];
  int   nCmp  = 0;
  int   nFail = 0;

  always #5 Clk = ~Clk;

  divisor_sequencial_if #(.WIDTH(WIDTH)) bif ();

  divisor_sequencial #(
    .WIDTH(WIDTH),
    .CNT_W(5)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nCmp++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one request, optionally pulse a second Start after injectAt edges
  // of CALC, then check latency, Busy length, results and Done width.
  task automatic doDiv(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int injectAt, input bit invariant);
    exp_t e;
    exp_t got;
    int   edges;
    int   busyCnt;
    e.q = (b == 16'd0) ? 16'hFFFF : a / b;
    e.r = (b == 16'd0) ? a : a % b;
    e.z = (b == 16'd0);
    bif.Start     = 1'b1;
    bif.Dividendo = a;
    bif.Divisor   = b;
    sb.push_back(e);
    tick();
    edges   = 0;
    busyCnt = int'(bif.Busy);
    bif.Start     = 1'b0;
    bif.Dividendo = 16'($urandom);
    bif.Divisor   = 16'($urandom);
    if (b != 16'd0) check("divzero_clear", bif.DivZero, 1'b0);
    while (!bif.Done && edges < 40) begin
      if (edges == injectAt) begin
        bif.Start     = 1'b1;
        bif.Dividendo = 16'd9;
        bif.Divisor   = 16'd3;
      end else begin
        bif.Start = 1'b0;
      end
      tick();
      edges++;
      busyCnt += int'(bif.Busy);
    end
    bif.Start = 1'b0;
    check("done_edges", edges, (b == 16'd0) ? 0 : 16);
    check("busy_cycles", busyCnt, (b == 16'd0) ? 0 : 16);
    got.q = bif.Quociente;
    got.r = bif.Resto;
    got.z = bif.DivZero;
    e = sb.pop_front();
    check("quociente", got.q, e.q);
    check("resto", got.r, e.r);
    check("divzero", got.z, e.z);
    if (invariant) begin
      check("inv_sum", 32'(got.q) * 32'(b) + 32'(got.r), 32'(a));
      check("inv_rem_lt_div", (got.r < b), 1'b1);
    end
    tick();
    check("done_pulse", bif.Done, 1'b0);
    check("hold_quociente", bif.Quociente, e.q);
    check("hold_divzero", bif.DivZero, e.z);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    Reset         = 1'b1;
    bif.Start     = 1'b0;
    bif.Dividendo = 16'd0;
    bif.Divisor   = 16'd0;
    repeat (2) tick();
    check("rst_quociente", bif.Quociente, 16'd0);
    check("rst_resto", bif.Resto, 16'd0);
    check("rst_busy", bif.Busy, 1'b0);
    check("rst_done", bif.Done, 1'b0);
    check("rst_divzero", bif.DivZero, 1'b0);
    Reset = 1'b0;
    tick();

    doDiv(16'd100, 16'd7, -1, 1'b1);
    doDiv(16'hFFFF, 16'd1, -1, 1'b1);
    doDiv(16'h7FFF, 16'h7FFF, -1, 1'b1);
    doDiv(16'd5, 16'd0, -1, 1'b0);
    doDiv(16'd0, 16'd9, -1, 1'b1);
    doDiv(16'd3, 16'd10, -1, 1'b1);

    // Second Start during CALC must be lost, not queued.
    doDiv(16'd5000, 16'd13, 5, 1'b1);
    tick();
    check("ignored_start_busy", bif.Busy, 1'b0);
    check("ignored_start_done", bif.Done, 1'b0);

    // Asynchronous reset in the middle of an operation.
    bif.Start     = 1'b1;
    bif.Dividendo = 16'd1000;
    bif.Divisor   = 16'd33;
    tick();
    bif.Start = 1'b0;
    repeat (7) tick();
    check("busy_midcalc", bif.Busy, 1'b1);
    #3 Reset = 1'b1;
    #1;
    check("async_rst_quociente", bif.Quociente, 16'd0);
    check("async_rst_resto", bif.Resto, 16'd0);
    check("async_rst_busy", bif.Busy, 1'b0);
    check("async_rst_done", bif.Done, 1'b0);
    check("async_rst_divzero", bif.DivZero, 1'b0);
    tick();
    Reset = 1'b0;
    tick();
    doDiv(16'd1000, 16'd33, -1, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      if (i % 4 == 0) begin
        rb = 16'($urandom_range(1, 15));
      end else begin
        rb = 16'($urandom_range(1, 65535));
      end
      doDiv(ra, rb, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
